// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared sizing constants and FSM state type for the log spawner
package log_pkg;

  localparam int         NUM_OF_LOGS = 30;
  localparam int         NUM_LANES   = 5;
  localparam logic [8:0] LANE_Y0     = 9'd64;
  localparam logic [8:0] LANE_PITCH  = 9'd32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    SEARCH    = 2'd2,
    SPAWN     = 2'd3
  } state_e;

endpackage

// File: rtl/log_slot_finder.sv
// rtl/log_slot_finder.sv - per-lane round-robin pointers and free-slot test
module log_slot_finder #(
  parameter int NUM_OF_LOGS = log_pkg::NUM_OF_LOGS,
  parameter int NUM_LANES   = log_pkg::NUM_LANES,
  parameter int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int STEP_W      = ((NUM_OF_LOGS / NUM_LANES) > 1) ? $clog2(NUM_OF_LOGS / NUM_LANES) : 1,
  parameter int SLOT_W      = (NUM_OF_LOGS > 1) ? $clog2(NUM_OF_LOGS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [LANE_W-1:0]      lane_i,
  input  logic [STEP_W-1:0]      step_i,
  input  logic                   advance_i,
  input  logic [NUM_OF_LOGS-1:0] enable_i,
  output logic [SLOT_W-1:0]      slot_o,
  output logic                   free_o
);

  localparam int PER_LANE = NUM_OF_LOGS / NUM_LANES;

  logic [STEP_W-1:0] ptr_q [NUM_LANES];
  logic [STEP_W-1:0] ptr_d;
  int                lane_off;

  // Candidate slot = lane base + (pointer + step) wrapped inside the lane; free when not enabled.
  always_comb begin
    lane_off = int'(ptr_q[lane_i]) + int'(step_i);
    if (lane_off >= PER_LANE) lane_off = lane_off - PER_LANE;
    slot_o = SLOT_W'(int'(lane_i) * PER_LANE + lane_off);
    free_o = ~enable_i[slot_o];
    ptr_d  = (lane_off + 1 >= PER_LANE) ? '0 : STEP_W'(lane_off + 1);
  end

  // Pointer of the spawning lane moves just past the slot that was filled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_LANES; i++) ptr_q[i] <= '0;
    end else if (advance_i) begin
      ptr_q[lane_i] <= ptr_d;
    end
  end

endmodule

// File: rtl/log_spawn_scheduler.sv
// rtl/log_spawn_scheduler.sv - tick-paced log spawner with per-lane round-robin slot search
module log_spawn_scheduler #(
  parameter int         NUM_OF_LOGS = log_pkg::NUM_OF_LOGS,
  parameter int         NUM_LANES   = log_pkg::NUM_LANES,
  parameter int         SPAWN_TICKS = 2,
  parameter logic [8:0] LANE_Y0     = log_pkg::LANE_Y0,
  parameter logic [8:0] LANE_PITCH  = log_pkg::LANE_PITCH
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     game_active,
  input  logic                     timer_done,
  input  logic [3:0]               random_0_15,
  input  logic [NUM_OF_LOGS-1:0]   log_offscreen,
  output logic [NUM_OF_LOGS-1:0]   enable,
  output logic [9*NUM_OF_LOGS-1:0] start_offsetY,
  output logic [9*NUM_OF_LOGS-1:0] start_offsetX,
  output logic                     spawn_pulse,
  output logic                     lane_full
);

  import log_pkg::*;

  localparam int         PER_LANE = NUM_OF_LOGS / NUM_LANES;
  localparam int         LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int         STEP_W   = (PER_LANE > 1) ? $clog2(PER_LANE) : 1;
  localparam int         SLOT_W   = (NUM_OF_LOGS > 1) ? $clog2(NUM_OF_LOGS) : 1;
  localparam logic [3:0] TICKS    = 4'(SPAWN_TICKS);

  logic [1:0]               rst_sync_q;
  logic                     rst;
  state_e                   state_q, state_d;
  logic [3:0]               tick_q, tick_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [3:0]               seed_q, seed_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic [NUM_OF_LOGS-1:0]   enable_q, enable_d;
  logic [9*NUM_OF_LOGS-1:0] offy_q, offy_d, offx_q, offx_d;
  logic                     spawn_q, spawn_d, full_q, full_d;
  logic                     advance;
  logic [SLOT_W-1:0]        find_slot;
  logic                     find_free;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  log_slot_finder #(
    .NUM_OF_LOGS (NUM_OF_LOGS),
    .NUM_LANES   (NUM_LANES),
    .LANE_W      (LANE_W),
    .STEP_W      (STEP_W),
    .SLOT_W      (SLOT_W)
  ) u_finder (
    .clk_i     (CLK),
    .rst_i     (rst),
    .lane_i    (lane_q),
    .step_i    (step_q),
    .advance_i (advance),
    .enable_i  (enable_q),
    .slot_o    (find_slot),
    .free_o    (find_free)
  );

  // Next-state logic; offscreen clears apply in every state, game_active low overrides all.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    lane_d   = lane_q;
    seed_d   = seed_q;
    step_d   = step_q;
    enable_d = enable_q & ~log_offscreen;
    offy_d   = offy_q;
    offx_d   = offx_q;
    spawn_d  = 1'b0;
    full_d   = 1'b0;
    advance  = 1'b0;
    if (!game_active) begin
      enable_d = '0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          tick_d  = '0;
          state_d = WAIT_TICK;
        end
        WAIT_TICK: begin
          if (timer_done) begin
            if (tick_q + 4'd1 == TICKS) begin
              tick_d  = '0;
              lane_d  = LANE_W'(random_0_15 % NUM_LANES);
              seed_d  = random_0_15;
              step_d  = '0;
              state_d = SEARCH;
            end else begin
              tick_d = tick_q + 4'd1;
            end
          end
        end
        SEARCH: begin
          if (find_free) begin
            state_d = SPAWN;
          end else if (step_q == STEP_W'(PER_LANE - 1)) begin
            full_d  = 1'b1;
            state_d = WAIT_TICK;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        SPAWN: begin
          enable_d[find_slot]              = 1'b1;
          offy_d[int'(find_slot)*9 +: 9]   = LANE_Y0 + 9'(lane_q) * LANE_PITCH;
          offx_d[int'(find_slot)*9 +: 9]   = lane_q[0] ? (9'd480 - {2'b00, seed_q, 3'b000}) : 9'd0;
          spawn_d                          = 1'b1;
          advance                          = 1'b1;
          state_d                          = WAIT_TICK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      lane_q   <= '0;
      seed_q   <= '0;
      step_q   <= '0;
      enable_q <= '0;
      offy_q   <= '0;
      offx_q   <= '0;
      spawn_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      lane_q   <= lane_d;
      seed_q   <= seed_d;
      step_q   <= step_d;
      enable_q <= enable_d;
      offy_q   <= offy_d;
      offx_q   <= offx_d;
      spawn_q  <= spawn_d;
      full_q   <= full_d;
    end
  end

  assign enable        = enable_q;
  assign start_offsetY = offy_q;
  assign start_offsetX = offx_q;
  assign spawn_pulse   = spawn_q;
  assign lane_full     = full_q;

endmodule
